// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end. Walks a sequential fetch pc, runs a
// req/gnt/rvalid handshake with instruction memory (one request in flight
// at most), and queues returned words in a small in-order buffer whose head
// feeds the IF/ID register. A redirect (jb) flushes the buffer, retargets
// the fetch pc and discards any response still in flight.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   stall             decode not taking the head entry this cycle
//   jb, jb_target     redirect request and its target (low two bits ignored)
//   imem_req/addr     fetch request and word-aligned address
//   imem_gnt          memory accepts the current request
//   imem_rvalid/rdata returned instruction word, one per granted request
//   pc_out/inst_out   head entry (zero when empty)
//   inst_valid        head entry present
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    // REQ: may issue; WAIT: response owed; DROP: response owed but stale.
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic [PW:0]   count;
    logic [PW-1:0] head, tail;
    logic [31:0]   buf_pc   [DEPTH];
    logic [31:0]   buf_inst [DEPTH];
    logic          issue, push, pop;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        push      = 1'b0;
        case (state)
            S_REQ: begin
                // Gating on count before issue guarantees the response a slot.
                imem_req = !rst && (count < FULL) && !jb;
                if (imem_req && imem_gnt) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push      = !jb;     // a response racing a redirect is stale
                    state_nxt = S_REQ;
                end else if (jb) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
        issue = imem_req && imem_gnt;
    end

    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && !stall && !jb;
    assign pc_out     = inst_valid ? buf_pc[head]   : 32'h0;
    assign inst_out   = inst_valid ? buf_inst[head] : 32'h0;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            pending_pc <= 32'h0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            state <= state_nxt;

            if (jb)         fetch_pc <= jb_target & ~32'd3;
            else if (issue) fetch_pc <= fetch_pc + 32'd4;

            if (issue) pending_pc <= fetch_pc;

            if (jb) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap naturally.
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the storage array is not reset; count alone says which entries
    // are live, and empty-buffer outputs are forced to zero above.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]   <= pending_pc;
            buf_inst[tail] <= imem_rdata;
        end
    end

    // A response landing in a full buffer means the single-outstanding
    // invariant has been broken somewhere.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == FULL));

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. A behavioural memory answers requests
// after a programmable latency; every grant pushes the expected {pc, inst}
// (from the bench's own fetch-pc model) onto a scoreboard queue, every pop
// at the decode side is compared against the queue head, and a redirect or
// reset empties the queue. Inputs change and outputs are sampled one time
// unit after the falling clock edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        jb = 1'b0;
    logic [31:0] jb_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .jb         (jb),
        .jb_target  (jb_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .inst_out   (inst_out),
        .inst_valid (inst_valid)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // memory model
    logic        gnt_en   = 1'b0;
    int          lat      = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    // reference model
    logic [31:0] exp_pc = RESET_PC;
    logic [63:0] exp_q[$];

    // per-cycle samples
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;
    logic [31:0] head_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick(input logic st, input logic j, input logic [31:0] tgt);
        logic [63:0] e;
        stall     = st;
        jb        = j;
        jb_target = tgt;
        imem_gnt  = 1'b0;
        if (mem_busy && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr);
            mem_busy    = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (mem_busy) mem_cnt--;
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = pc_out;
        s_inst  = inst_out;
        if (imem_req && gnt_en) begin
            imem_gnt = 1'b1;
            check("req_addr", imem_addr, exp_pc);
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = lat - 1;
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        if (inst_valid && !st && !j) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc", pc_out, e[63:32]);
                check("sb_inst", inst_out, e[31:0]);
            end
        end
        if (j) begin
            exp_q.delete();
            exp_pc = tgt & ~32'd3;
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        gnt_en = 1'b0;
        repeat (6) tick(1'b0, 1'b0, 32'h0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_empty"}, 32'(s_valid), 32'd0);
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b1;
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pc", pc_out, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- 1: sequential fetch, 1-cycle memory ----
        gnt_en = 1'b1; lat = 1;
        tick(1'b0, 1'b0, 32'h0);
        check("t1_first_req", 32'(s_req), 32'd1);
        check("t1_first_addr", s_addr, RESET_PC);
        check("t1_no_valid_yet", 32'(s_valid), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t1_no_req_in_wait", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t1_valid", 32'(s_valid), 32'd1);
        check("t1_pc", s_pc, RESET_PC);
        check("t1_inst", s_inst, mem_word(RESET_PC));
        check("t1_addr2", s_addr, RESET_PC + 32'd4);
        repeat (5) tick(1'b0, 1'b0, 32'h0);
        drain("t1");

        // ---- 2: stall fills buffer, then two ordered pops ----
        gnt_en = 1'b1; lat = 1;
        head_pc = exp_pc;
        repeat (3) tick(1'b1, 1'b0, 32'h0);
        check("t2_hold_early", s_pc, head_pc);
        repeat (2) tick(1'b1, 1'b0, 32'h0);
        check("t2_full_no_req", 32'(s_req), 32'd0);
        check("t2_full_valid", 32'(s_valid), 32'd1);
        check("t2_head_pc", s_pc, head_pc);
        check("t2_head_inst", s_inst, mem_word(head_pc));
        tick(1'b0, 1'b0, 32'h0);
        check("t2_pop_cycle_no_req", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t2_second_pc", s_pc, head_pc + 32'd4);
        repeat (2) tick(1'b0, 1'b0, 32'h0);
        drain("t2");

        // ---- 3: jb while waiting, stale word arrives later ----
        gnt_en = 1'b1; lat = 3;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0100);
        check("t3_jb_no_req", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t3_drop_no_req", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t3_stale_dropped", 32'(s_valid), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t3_target_req", 32'(s_req), 32'd1);
        check("t3_target_addr", s_addr, 32'h0000_0100);
        check("t3_still_empty", 32'(s_valid), 32'd0);
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t3_target_pc", s_pc, 32'h0000_0100);
        check("t3_target_valid", 32'(s_valid), 32'd1);
        drain("t3");

        // ---- 4a: jb coincident with rvalid ----
        gnt_en = 1'b1; lat = 1;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0200);
        check("t4a_jb_no_req", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t4a_target_addr", s_addr, 32'h0000_0200);
        check("t4a_no_stale_push", 32'(s_valid), 32'd0);
        gnt_en = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        // ---- 4b: jb in REQ with gnt low, under stall ----
        tick(1'b1, 1'b0, 32'h0);
        check("t4b_head_pc", s_pc, 32'h0000_0200);
        check("t4b_addr_wait_gnt", s_addr, 32'h0000_0204);
        tick(1'b1, 1'b0, 32'h0);
        check("t4b_addr_stable", s_addr, 32'h0000_0204);
        check("t4b_req_held", 32'(s_req), 32'd1);
        tick(1'b1, 1'b1, 32'h0000_0300);
        check("t4b_jb_no_req", 32'(s_req), 32'd0);
        gnt_en = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        check("t4b_target_req", 32'(s_req), 32'd1);
        check("t4b_target_addr", s_addr, 32'h0000_0300);
        check("t4b_flushed", 32'(s_valid), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t4b_target_pc", s_pc, 32'h0000_0300);
        drain("t4");

        // ---- 5: address wrap, unaligned target ----
        gnt_en = 1'b1; lat = 1;
        tick(1'b0, 1'b1, 32'hFFFF_FFFF);
        check("t5_jb_no_req", 32'(s_req), 32'd0);
        tick(1'b0, 1'b0, 32'h0);
        check("t5_addr_top", s_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t5_addr_wrap", s_addr, 32'h0000_0000);
        check("t5_pc_top", s_pc, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t5_pc_wrap", s_pc, 32'h0000_0000);
        check("t5_inst_wrap", s_inst, mem_word(32'h0));

        // ---- 6: reset while waiting with one buffered entry ----
        tick(1'b1, 1'b0, 32'h0);
        lat = 3;
        tick(1'b1, 1'b0, 32'h0);
        check("t6_buffered_pc", s_pc, 32'h0000_0004);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(imem_req), 32'd0);
        check("t6_rst_addr", imem_addr, RESET_PC);
        check("t6_rst_pc", pc_out, 32'h0);
        check("t6_rst_inst", inst_out, 32'h0);
        check("t6_rst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_pc = RESET_PC;
        gnt_en = 1'b0;
        tick(1'b0, 1'b0, 32'h0);
        check("t6_restart_req", 32'(s_req), 32'd1);
        check("t6_restart_addr", s_addr, RESET_PC);
        repeat (2) tick(1'b0, 1'b0, 32'h0);   // late rvalid lands in the second
        tick(1'b0, 1'b0, 32'h0);
        check("t6_late_not_pushed", 32'(s_valid), 32'd0);
        gnt_en = 1'b1; lat = 1;
        repeat (2) tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        check("t6_restart_pc", s_pc, RESET_PC);
        check("t6_restart_valid", 32'(s_valid), 32'd1);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
